// File: rtl/peripheral_noc_vc_buffer.sv
// Multi-virtual-channel flit buffer: per-channel FIFOs merged onto one link by a
// packet-locked round-robin arbiter. Define PERIPHERAL_NOC_VC_BUFFER_LEVEL_EN to add the "level" port.
module peripheral_noc_vc_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int FULLPACKET = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHANNELS-1:0]   out_vc
`ifdef PERIPHERAL_NOC_VC_BUFFER_LEVEL_EN
    ,
    output logic [CHANNELS*(AW+1)-1:0] level
`endif
);

    localparam int         CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic       ST_IDLE   = 1'b0;
    localparam logic       ST_LOCKED = 1'b1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "peripheral_noc_vc_buffer: DEPTH must be a power of two >= 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $fatal(1, "peripheral_noc_vc_buffer: CHANNELS must be >= 1");
    end

    logic [FLIT_WIDTH:0] mem_q     [CHANNELS][DEPTH];
    logic [AW:0]         count_q   [CHANNELS];
    logic [AW:0]         count_d   [CHANNELS];
    logic [AW:0]         lastcnt_q [CHANNELS];
    logic [AW:0]         lastcnt_d [CHANNELS];
    logic [AW-1:0]       wr_ptr_q  [CHANNELS];
    logic [AW-1:0]       wr_ptr_d  [CHANNELS];
    logic [AW-1:0]       rd_ptr_q  [CHANNELS];
    logic [AW-1:0]       rd_ptr_d  [CHANNELS];

    logic                state_q, state_d;
    logic [CW-1:0]       lock_vc_q, lock_vc_d;
    logic [CW-1:0]       rr_q, rr_d;

    logic [CHANNELS-1:0] has_space, wr_sel, wr_en, rd_en, eligible;
    logic [CW-1:0]       grant;
    logic                found;
    logic                xfer;
    logic [FLIT_WIDTH:0] head;

    // Only the lowest requesting channel may write; the others see in_ready low.
    assign wr_sel = in_valid & (~in_valid + CHANNELS'(1));

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            has_space[c] = (count_q[c] < CNT_FULL);
            if (FULLPACKET != 0) eligible[c] = (lastcnt_q[c] != '0);
            else                 eligible[c] = (count_q[c] != '0);
        end
    end

    assign in_ready = has_space & ~(in_valid & ~wr_sel);
    assign wr_en    = wr_sel & has_space;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = rr_q;
        found     = 1'b0;
        out_valid = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant     = lock_vc_q;
            out_valid = (count_q[lock_vc_q] != '0);
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                if (!found && eligible[(int'(rr_q) + i) % CHANNELS]) begin
                    grant = CW'((int'(rr_q) + i) % CHANNELS);
                    found = 1'b1;
                end
            end
            out_valid = found;
        end
    end

    assign head     = mem_q[grant][rd_ptr_q[grant]];
    assign out_flit = head[FLIT_WIDTH-1:0];
    assign out_last = head[FLIT_WIDTH];
    assign out_vc   = out_valid ? (CHANNELS'(1) << grant) : '0;
    assign xfer     = out_valid & out_ready;
    assign rd_en    = xfer ? out_vc : '0;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            count_d[c]   = count_q[c];
            lastcnt_d[c] = lastcnt_q[c];
            wr_ptr_d[c]  = wr_ptr_q[c] + AW'(wr_en[c]);
            rd_ptr_d[c]  = rd_ptr_q[c] + AW'(rd_en[c]);
            case ({wr_en[c], rd_en[c]})
                2'b10:   count_d[c] = count_q[c] + 1'b1;
                2'b01:   count_d[c] = count_q[c] - 1'b1;
                default: count_d[c] = count_q[c];
            endcase
            case ({wr_en[c] & in_last, rd_en[c] & out_last})
                2'b10:   lastcnt_d[c] = lastcnt_q[c] + 1'b1;
                2'b01:   lastcnt_d[c] = lastcnt_q[c] - 1'b1;
                default: lastcnt_d[c] = lastcnt_q[c];
            endcase
        end
    end

    // A packet's first non-last flit locks the link; its last flit frees it and moves rr.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_d      = rr_q;
        if (xfer) begin
            if (out_last) begin
                state_d = ST_IDLE;
                rr_d    = grant;
            end else if (state_q == ST_IDLE) begin
                state_d   = ST_LOCKED;
                lock_vc_d = grant;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= '0;
                lastcnt_q[c] <= '0;
                wr_ptr_q[c]  <= '0;
                rd_ptr_q[c]  <= '0;
            end
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
            rr_q      <= CW'(CHANNELS - 1);
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= count_d[c];
                lastcnt_q[c] <= lastcnt_d[c];
                wr_ptr_q[c]  <= wr_ptr_d[c];
                rd_ptr_q[c]  <= rd_ptr_d[c];
            end
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_q      <= rr_d;
        end
    end

    // NOTE: flit storage has no reset; counts and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= {in_last, in_flit};
        end
    end

`ifdef PERIPHERAL_NOC_VC_BUFFER_LEVEL_EN
    always_comb begin
        level = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            level[c*(AW+1) +: AW+1] = count_q[c];
        end
    end
`endif

endmodule

// File: tb/tb_peripheral_noc_vc_buffer.sv
// Directed bench for peripheral_noc_vc_buffer: two instances (plain and full-packet)
// with DEPTH=4, CHANNELS=2 share the stimulus; expected values are hand-computed.
module tb_peripheral_noc_vc_buffer;

    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] in_flit = '0;
    logic          in_last = 1'b0;
    logic [1:0]    in_valid = '0;
    logic          out_ready = 1'b0;

    logic [1:0]    a_in_ready, b_in_ready;
    logic [FW-1:0] a_out_flit, b_out_flit;
    logic          a_out_last, b_out_last;
    logic          a_out_valid, b_out_valid;
    logic [1:0]    a_out_vc, b_out_vc;
`ifdef PERIPHERAL_NOC_VC_BUFFER_LEVEL_EN
    logic [5:0]    a_level, b_level;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    peripheral_noc_vc_buffer #(.FLIT_WIDTH(FW), .DEPTH(4), .CHANNELS(2), .FULLPACKET(0)) u_dut (
`ifdef PERIPHERAL_NOC_VC_BUFFER_LEVEL_EN
        .level     (a_level),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .out_flit  (a_out_flit),
        .out_last  (a_out_last),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_vc    (a_out_vc)
    );

    peripheral_noc_vc_buffer #(.FLIT_WIDTH(FW), .DEPTH(4), .CHANNELS(2), .FULLPACKET(1)) u_fp (
`ifdef PERIPHERAL_NOC_VC_BUFFER_LEVEL_EN
        .level     (b_level),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .out_flit  (b_out_flit),
        .out_last  (b_out_last),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_vc    (b_out_vc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs mid-cycle; outputs are sampled 1 ns later, well before the next posedge.
    task automatic drive(input logic [1:0] v, input logic [FW-1:0] f, input logic l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_flit   = f;
        in_last   = l;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic expect_out(input string tag, input bit fp, input logic v,
                              input logic [1:0] vc, input logic [FW-1:0] f, input logic l);
        logic          ov, ol;
        logic [1:0]    ovc;
        logic [FW-1:0] of;
        ov  = fp ? b_out_valid : a_out_valid;
        ovc = fp ? b_out_vc    : a_out_vc;
        of  = fp ? b_out_flit  : a_out_flit;
        ol  = fp ? b_out_last  : a_out_last;
        check({tag, ".valid"}, 64'(ov), 64'(v));
        check({tag, ".vc"}, 64'(ovc), 64'(vc));
        if (v) begin
            check({tag, ".flit"}, 64'(of), 64'(f));
            check({tag, ".last"}, 64'(ol), 64'(l));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst.valid", 64'(a_out_valid), 64'(0));
        check("rst.vc", 64'(a_out_vc), 64'(0));
        check("rst.in_ready", 64'(a_in_ready), 64'(2'b11));

        // Three-flit packet on VC0 with the sink always ready
        drive(2'b01, 32'hA000_0000, 1'b0, 1'b1);
        expect_out("t1.s0", 0, 1'b0, 2'b00, '0, 1'b0);
        drive(2'b01, 32'hA000_0001, 1'b0, 1'b1);
        expect_out("t1.s1", 0, 1'b1, 2'b01, 32'hA000_0000, 1'b0);
        drive(2'b01, 32'hA000_0002, 1'b1, 1'b1);
        expect_out("t1.s2", 0, 1'b1, 2'b01, 32'hA000_0001, 1'b0);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("t1.s3", 0, 1'b1, 2'b01, 32'hA000_0002, 1'b1);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("t1.s4", 0, 1'b0, 2'b00, '0, 1'b0);

        // Multi-hot in_valid: only VC0 accepted
        do_reset();
        drive(2'b11, 32'h0000_0BAD, 1'b1, 1'b0);
        check("mh.in_ready", 64'(a_in_ready), 64'(2'b01));
        drive(2'b00, '0, 1'b0, 1'b1);
        check("mh.in_ready_idle", 64'(a_in_ready), 64'(2'b11));
        expect_out("mh.s1", 0, 1'b1, 2'b01, 32'h0000_0BAD, 1'b1);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("mh.s2", 0, 1'b0, 2'b00, '0, 1'b0);

        // Fill VC1 to DEPTH, refuse a fifth flit, then drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 32'hB000_0000 + FW'(i), (i == 3), 1'b0);
            check($sformatf("full.rdy%0d", i), 64'(a_in_ready), 64'(2'b11));
        end
        drive(2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("full.in_ready", 64'(a_in_ready), 64'(2'b01));
        expect_out("full.head", 0, 1'b1, 2'b10, 32'hB000_0000, 1'b0);
`ifdef PERIPHERAL_NOC_VC_BUFFER_LEVEL_EN
        check("full.level1", 64'(a_level[5:3]), 64'(4));
        check("full.level0", 64'(a_level[2:0]), 64'(0));
`endif
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, '0, 1'b0, 1'b1);
            expect_out($sformatf("full.drain%0d", i), 0, 1'b1, 2'b10, 32'hB000_0000 + FW'(i), (i == 3));
        end
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("full.empty", 0, 1'b0, 2'b00, '0, 1'b0);
        check("full.in_ready_after", 64'(a_in_ready), 64'(2'b11));

        // Two 2-flit packets per VC, then round-robin with packet locking
        do_reset();
        for (int i = 0; i < 4; i++) drive(2'b01, 32'hC000_0000 + FW'(i), i[0], 1'b0);
        for (int i = 0; i < 4; i++) drive(2'b10, 32'hD000_0000 + FW'(i), i[0], 1'b0);
        for (int k = 0; k < 8; k++) begin
            int          pkt;
            logic [1:0]  evc;
            logic [FW-1:0] ef;
            pkt = k / 2;
            evc = (pkt % 2 == 0) ? 2'b01 : 2'b10;
            ef  = ((pkt % 2 == 0) ? 32'hC000_0000 : 32'hD000_0000) + FW'((pkt / 2) * 2 + k % 2);
            drive(2'b00, '0, 1'b0, 1'b1);
            expect_out($sformatf("rr.k%0d", k), 0, 1'b1, evc, ef, (k % 2 == 1));
        end
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("rr.empty", 0, 1'b0, 2'b00, '0, 1'b0);

        // Full-packet mode: no output until the last flit is stored
        do_reset();
        drive(2'b01, 32'hF000_0000, 1'b0, 1'b1);
        expect_out("fp.w0", 1, 1'b0, 2'b00, '0, 1'b0);
        drive(2'b01, 32'hF000_0001, 1'b0, 1'b1);
        expect_out("fp.w1", 1, 1'b0, 2'b00, '0, 1'b0);
        drive(2'b01, 32'hF000_0002, 1'b1, 1'b1);
        expect_out("fp.w2", 1, 1'b0, 2'b00, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, '0, 1'b0, 1'b1);
            expect_out($sformatf("fp.r%0d", i), 1, 1'b1, 2'b01, 32'hF000_0000 + FW'(i), (i == 2));
        end
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("fp.empty", 1, 1'b0, 2'b00, '0, 1'b0);

        // Locked on an empty VC0 while VC1 is full
        do_reset();
        for (int i = 0; i < 4; i++) drive(2'b10, 32'hE000_0000 + FW'(i), (i == 3), 1'b0);
        drive(2'b01, 32'h6000_0000, 1'b0, 1'b0);
        check("lk.in_ready", 64'(a_in_ready), 64'(2'b01));
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("lk.first", 0, 1'b1, 2'b01, 32'h6000_0000, 1'b0);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("lk.starve0", 0, 1'b0, 2'b00, '0, 1'b0);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("lk.starve1", 0, 1'b0, 2'b00, '0, 1'b0);
        drive(2'b01, 32'h6000_0001, 1'b1, 1'b1);
        expect_out("lk.nowt", 0, 1'b0, 2'b00, '0, 1'b0);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("lk.tail", 0, 1'b1, 2'b01, 32'h6000_0001, 1'b1);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("lk.vc1", 0, 1'b1, 2'b10, 32'hE000_0000, 1'b0);

        // Reset mid-packet: lock on VC0, rr pointing at VC0, both VCs holding flits
        do_reset();
        drive(2'b01, 32'h5000_0000, 1'b1, 1'b0);
        drive(2'b01, 32'h5000_0001, 1'b0, 1'b0);
        drive(2'b01, 32'h5000_0002, 1'b0, 1'b0);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("mr.single", 0, 1'b1, 2'b01, 32'h5000_0000, 1'b1);
        drive(2'b10, 32'h5100_0000, 1'b0, 1'b1);
        expect_out("mr.lockhead", 0, 1'b1, 2'b01, 32'h5000_0001, 1'b0);
        do_reset();
        expect_out("mr.after", 0, 1'b0, 2'b00, '0, 1'b0);
        check("mr.in_ready", 64'(a_in_ready), 64'(2'b11));
        drive(2'b10, 32'h7100_0000, 1'b1, 1'b0);
        expect_out("mr.w1", 0, 1'b0, 2'b00, '0, 1'b0);
        drive(2'b01, 32'h7000_0000, 1'b1, 1'b0);
        expect_out("mr.unlocked", 0, 1'b1, 2'b10, 32'h7100_0000, 1'b1);
        drive(2'b00, '0, 1'b0, 1'b0);
        expect_out("mr.prio", 0, 1'b1, 2'b01, 32'h7000_0000, 1'b1);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("mr.d0", 0, 1'b1, 2'b01, 32'h7000_0000, 1'b1);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("mr.d1", 0, 1'b1, 2'b10, 32'h7100_0000, 1'b1);
        drive(2'b00, '0, 1'b0, 1'b1);
        expect_out("mr.empty", 0, 1'b0, 2'b00, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
